handshake_rr_arbiter: RTL
=========================

Name: handshake_rr_arbiter

Overview:
- Round-robin arbiter that shares one valid/ready destination between NUM_SRC valid/ready source channels.
- Holds the grant for a whole packet, i.e. until the source's last beat.
- Drives the destination from a one-entry registered output stage.
- Sits in front of the backward-registered slices in the bus-handshake chain: several producers feed one shared downstream slice/FIFO.

Parameters:
- NUM_SRC, 4, number of source channels (2..16)
- WIDTH, 8, data width per channel
- MAX_BURST, 16, beat limit per grant; used only with BURST_LIMIT_EN (1..65535)

Ports:
- clk  in  1  clock, all logic on rising edge
- s_rst_n  in  1  asynchronous active-low reset
- src_vaild  in  NUM_SRC  per-channel valid
- src_data_in  in  NUM_SRC*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- src_last  in  NUM_SRC  per-channel end-of-packet flag, qualified by valid
- src_ready  out  NUM_SRC  per-channel ready; at most one bit high
- dst_vaild  out  1  output stage holds a beat
- dst_data_out  out  WIDTH  registered data
- dst_last  out  1  registered last flag
- dst_ready  in  1  destination ready
- grant_id  out  clog2(NUM_SRC), min 1  currently or most recently granted channel
- busy  out  1  state != IDLE or dst_vaild

Behaviour:
- Reset values (async assert, sync release): state=IDLE; ptr=0; grant_id=0; dst_vaild=0; dst_data_out=0; dst_last=0; src_ready=0; beat_cnt=0.
- FSM states: IDLE, ARB, XFER.
- IDLE -> ARB on the first cycle that any src_vaild bit is sampled high.
- ARB, one cycle:
  - grant_id <= first i with src_vaild[i]=1, searching ptr, ptr+1, ..., NUM_SRC-1, 0, ..., ptr-1.
  - Next state XFER.
  - If no request remains, return to IDLE with grant_id unchanged.
- XFER:
  - src_ready[grant_id] = (!dst_vaild | dst_ready); all other src_ready bits are 0. src_ready is combinational from the state, dst_vaild and dst_ready only; it never depends on src_vaild.
  - Accepted beat = src_vaild[g] & src_ready[g]. On an accepted beat: dst_data_out <= data[g]; dst_last <= src_last[g]; dst_vaild <= 1; beat_cnt++.
- Output register:
  - If dst_vaild & dst_ready and no new beat is accepted that cycle, dst_vaild <= 0.
  - A simultaneous drain and load keeps dst_vaild=1 with the new data, giving full throughput of 1 beat/cycle.
  - dst_data_out and dst_last are stable while dst_vaild & !dst_ready.
- End of grant, on an accepted beat with src_last[g]=1:
  - ptr <= (g+1) mod NUM_SRC; beat_cnt <= 0.
  - Next state is ARB if any src_vaild is high that cycle, otherwise IDLE.
- Latency: src_vaild sampled in IDLE at cycle 0 -> ARB at cycle 1 -> src_ready high at cycle 2 (if the output stage is free) -> dst_vaild at cycle 3.
- Inter-packet bubble: exactly 1 cycle (ARB).
- Granted source drops valid mid-packet: the arbiter stays in XFER holding the grant and waiting; no re-arbitration.
- Simultaneous requests: resolved purely by ptr order. No starvation: every waiting source is granted within NUM_SRC grants.
- dst_ready low indefinitely: the pending beat is held, src_ready stays low, and the arbiter stays in XFER.
- Reset mid-packet: all state is cleared immediately and any pending output beat is discarded.
- beat_cnt is 16 bits and saturates at 65535.
- grant_id is not changed outside ARB.

Optional Feature:
- Macro: BURST_LIMIT_EN
- Defined:
  - The grant also ends on the accepted beat where beat_cnt reaches MAX_BURST, even without src_last.
  - ptr advances as for a normal end of grant.
  - dst_last on that beat = the source's src_last (not forced).
  - The source resumes its packet on its next grant.
- Undefined:
  - The grant ends only on src_last; MAX_BURST is ignored.
  - No beat counter is synthesized; beat_cnt is removed.

Test Plan:
- Single source: ch2 sends 3 beats (0x11, 0x22, 0x33 with last), dst_ready=1 -> src_ready[2] rises 2 cycles after valid; dst sees 0x11/0x22/0x33 on consecutive cycles, dst_last only on 0x33; grant_id=2; ptr=3.
- Round robin: all 4 channels valid with 1-beat packets, ptr=0 -> grant order 0,1,2,3,0; one idle ARB cycle between packets; src_ready is never multi-hot.
- Backpressure: dst_ready held 0 for 5 cycles after the first beat of ch1 -> dst_data_out is stable and src_ready[1]=0 for those 5 cycles; no beat lost or duplicated after release.
- Gap in packet: ch0 drops src_vaild for 3 cycles mid-packet while ch3 requests -> grant_id stays 0 until ch0's last beat; ch3 is then granted.
- Reset mid-transfer: assert s_rst_n=0 asynchronously while dst_vaild=1 -> dst_vaild, src_ready and busy go 0 without waiting for a clock edge; after release the arbiter is in IDLE with ptr=0.
- BURST_LIMIT_EN, MAX_BURST=4: ch0 sends a 6-beat packet while ch1 requests -> after 4 beats of ch0, ch1's packet follows, then ch0's remaining 2 beats; dst_last only on the 6th ch0 beat.

Source files
------------

// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter: packet-granular round-robin valid/ready arbiter with a one-entry registered output stage; optional per-grant beat limit under `BURST_LIMIT_EN
module handshake_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int WIDTH = 8,
  parameter int MAX_BURST = 16,
  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     s_rst_n,
  input  logic [NUM_SRC-1:0]       src_vaild,
  input  logic [NUM_SRC*WIDTH-1:0] src_data_in,
  input  logic [NUM_SRC-1:0]       src_last,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic                     dst_vaild,
  output logic [WIDTH-1:0]         dst_data_out,
  output logic                     dst_last,
  input  logic                     dst_ready,
  output logic [GW-1:0]            grant_id,
  output logic                     busy
);
  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d, grant_q, grant_d, next_id;
  logic dst_vaild_q, dst_vaild_d, dst_last_q, dst_last_d;
  logic [WIDTH-1:0] dst_data_q, dst_data_d, sel_data;
  logic found, sel_vaild, sel_last, out_free, acc, eog, hit;
  // rotating priority search: first pass from ptr upward, second pass wraps to the low channels
  always_comb begin
    found = 1'b0;
    next_id = ptr_q;
    for (int i = 0; i < NUM_SRC; i++)
      if (!found && i >= int'(ptr_q) && src_vaild[i]) begin
        found = 1'b1;
        next_id = i[GW-1:0];
      end
    for (int i = 0; i < NUM_SRC; i++)
      if (!found && src_vaild[i]) begin
        found = 1'b1;
        next_id = i[GW-1:0];
      end
  end
  // mux the granted channel; ready depends only on state and output-stage occupancy
  always_comb begin
    sel_vaild = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (grant_q == i[GW-1:0]) begin
        sel_vaild = src_vaild[i];
        sel_last = src_last[i];
        sel_data = src_data_in[i*WIDTH +: WIDTH];
        src_ready[i] = (state_q == XFER) && out_free;
      end
  end
  assign out_free = !dst_vaild_q || dst_ready;
  assign acc = (state_q == XFER) && sel_vaild && out_free;
  assign eog = acc && (sel_last || hit);
`ifdef BURST_LIMIT_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;
  assign hit = ({1'b0, beat_cnt_q} + 17'd1) == 17'(MAX_BURST);
  // beats accepted in the current grant, saturating, cleared when the grant ends
  always_comb beat_cnt_d = eog ? 16'd0 : (acc && beat_cnt_q != 16'hffff) ? beat_cnt_q + 16'd1 : beat_cnt_q;
  // beat counter register
  always_ff @(posedge clk or negedge s_rst_n)
    if (!s_rst_n) beat_cnt_q <= '0;
    else beat_cnt_q <= beat_cnt_d;
`else
  assign hit = 1'b0;
`endif
  // next state, grant/pointer update and output-stage load/drain
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    dst_vaild_d = (dst_vaild_q && !dst_ready) || acc;
    dst_data_d = acc ? sel_data : dst_data_q;
    dst_last_d = acc ? sel_last : dst_last_q;
    if (state_q == IDLE && |src_vaild) state_d = ARB;
    if (state_q == ARB) begin
      state_d = found ? XFER : IDLE;
      grant_d = found ? next_id : grant_q;
    end
    if (eog) begin
      ptr_d = (grant_q == GW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
      state_d = |src_vaild ? ARB : IDLE;
    end
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge s_rst_n)
    if (!s_rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_q <= '0;
      dst_vaild_q <= 1'b0;
      dst_data_q <= '0;
      dst_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      dst_vaild_q <= dst_vaild_d;
      dst_data_q <= dst_data_d;
      dst_last_q <= dst_last_d;
    end
  assign dst_vaild = dst_vaild_q;
  assign dst_data_out = dst_data_q;
  assign dst_last = dst_last_q;
  assign grant_id = grant_q;
  assign busy = (state_q != IDLE) || dst_vaild_q;
endmodule
